// File: rtl/stc_prog.sv
// stc_prog: programmable sensitivity time control for radar video.
// Range-dependent gain from a runtime-loaded breakpoint table, 2-cycle multiply pipe.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_trig        sweep trigger (level, edge detected inside)
//   i_sample_en   ADC strobe, i_vid_in valid
//   i_vid_in      raw video sample
//   i_bypass      force unity gain
//   i_cfg_we/addr/range/gain  breakpoint table write port
//   o_cfg_err     pulse: write rejected
//   o_vid_out/o_vid_valid     gain-controlled video
//   o_sweep_active, o_range_idx  sweep status / range counter
//   o_trig_overrun            pulse: trigger edge during active sweep
module stc_prog #(
  parameter int DATA_W       = 12,
  parameter int GAIN_W       = 12,
  parameter int RANGE_W      = 12,
  parameter int SAMPLE_LIMIT = 2626,
  parameter int SEGS         = 16,
  parameter int RETRIG       = 0,
  localparam int AW          = $clog2(SEGS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_trig,
  input  logic               i_sample_en,
  input  logic [DATA_W-1:0]  i_vid_in,
  input  logic               i_bypass,
  input  logic               i_cfg_we,
  input  logic [AW-1:0]      i_cfg_addr,
  input  logic [RANGE_W-1:0] i_cfg_range,
  input  logic [GAIN_W-1:0]  i_cfg_gain,
  output logic               o_cfg_err,
  output logic [DATA_W-1:0]  o_vid_out,
  output logic               o_vid_valid,
  output logic               o_sweep_active,
  output logic [RANGE_W-1:0] o_range_idx,
  output logic               o_trig_overrun
);

  localparam logic [RANGE_W-1:0] LIM =
    RANGE_W'(SAMPLE_LIMIT);
  localparam logic [GAIN_W-1:0] UNITY =
    {1'b1, {(GAIN_W-1){1'b0}}};
  localparam logic [AW-1:0] LAST = AW'(SEGS-1);
  localparam int PW = DATA_W + GAIN_W;

  logic               r_trig_d;
  logic [RANGE_W-1:0] r_range;
  logic [AW-1:0]      r_seg;

  // Shadow table takes writes; active table is what
  // the running sweep uses, refreshed at sweep start.
  logic [RANGE_W-1:0] r_sh_rng   [SEGS];
  logic [GAIN_W-1:0]  r_sh_gain  [SEGS];
  logic [RANGE_W-1:0] r_act_rng  [SEGS];
  logic [GAIN_W-1:0]  r_act_gain [SEGS];

  logic               r_s1_v;
  logic [DATA_W-1:0]  r_s1_vid;
  logic [GAIN_W-1:0]  r_s1_gain;
  logic               r_vv;
  logic [DATA_W-1:0]  r_vo;
  logic               r_err;
  logic               r_ovr;

  logic               w_edge;
  logic               w_active;
  logic               w_start;
  logic               w_we_ok;
  logic [AW-1:0]      w_nxt;
  logic               w_can;
  logic [AW-1:0]      w_seg;
  logic [GAIN_W-1:0]  w_gain;
  logic [PW-1:0]      w_prod;
  logic [DATA_W:0]    w_y;
  logic [DATA_W-1:0]  w_sat;

  assign w_edge   = i_trig & ~r_trig_d;
  assign w_active = r_range < LIM;
  assign w_start  = w_edge &
    (~w_active | (RETRIG != 0));
  assign w_we_ok  = i_cfg_we & ~w_active & ~w_edge;

  // Pointer may step to the next entry only while the
  // table is still ascending at that point.
  assign w_nxt = r_seg + AW'(1);
  assign w_can = (r_seg != LAST) &&
    (r_act_rng[w_nxt] > r_act_rng[r_seg]) &&
    (r_range >= r_act_rng[w_nxt]);
  assign w_seg = (w_active && w_can) ? w_nxt : r_seg;

  always_comb begin
    w_gain = r_act_gain[w_seg];
    unique case (1'b1)
      i_bypass: w_gain = UNITY;
      w_start:  w_gain = r_sh_gain[0];
      default:  w_gain = r_act_gain[w_seg];
    endcase
  end

  // Product never exceeds 2**(DATA_W+1) after the
  // shift, so the top bit alone flags overflow.
  assign w_prod = PW'(r_s1_vid) * PW'(r_s1_gain);
  assign w_y    = (DATA_W+1)'(w_prod >> (GAIN_W-1));
  assign w_sat  = w_y[DATA_W] ? '1 : w_y[DATA_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_trig_d  <= 1'b0;
      r_range   <= LIM;
      r_seg     <= '0;
      r_s1_v    <= 1'b0;
      r_s1_vid  <= '0;
      r_s1_gain <= '0;
      r_vv      <= 1'b0;
      r_vo      <= '0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      for (int i = 0; i < SEGS; i++) begin
        r_sh_rng[i]   <= '0;
        r_sh_gain[i]  <= UNITY;
        r_act_rng[i]  <= '0;
        r_act_gain[i] <= UNITY;
      end
    end else begin
      r_trig_d <= i_trig;
      r_err    <= i_cfg_we & ~w_we_ok;
      r_ovr    <= w_edge & w_active;

      // A sample coincident with restart takes idx 0.
      if (w_start)
        r_range <= i_sample_en ?
          RANGE_W'(1) : '0;
      else if (w_active && i_sample_en)
        r_range <= r_range + RANGE_W'(1);

      r_seg <= w_start ? '0 : w_seg;

      if (w_start) begin
        for (int i = 0; i < SEGS; i++) begin
          r_act_rng[i]  <= r_sh_rng[i];
          r_act_gain[i] <= r_sh_gain[i];
        end
      end
      if (w_we_ok) begin
        r_sh_rng[i_cfg_addr]  <= i_cfg_range;
        r_sh_gain[i_cfg_addr] <= i_cfg_gain;
      end

      r_s1_v    <= i_sample_en;
      r_s1_vid  <= i_vid_in;
      r_s1_gain <= w_gain;
      r_vv      <= r_s1_v;
      if (r_s1_v)
        r_vo <= w_sat;
    end
  end

  assign o_cfg_err      = r_err;
  assign o_vid_out      = r_vo;
  assign o_vid_valid    = r_vv;
  assign o_sweep_active = w_active;
  assign o_range_idx    = r_range;
  assign o_trig_overrun = r_ovr;

endmodule

// File: tb/tb_stc_prog.sv
// tb_stc_prog: directed bench for stc_prog.
// Spec-level model (table scan per sample) plus literal pins.
module tb_stc_prog;

  localparam int LIM   = 2626;
  localparam int SEGS  = 16;
  localparam int UNITY = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trig = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] vid_in = '0;
  logic        bypass = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [11:0] cfg_range = '0;
  logic [11:0] cfg_gain = '0;

  logic        o_cfg_err, o_vid_valid;
  logic        o_sweep_active, o_trig_overrun;
  logic [11:0] o_vid_out, o_range_idx;

  logic        r_cfg_err, r_vid_valid;
  logic        r_sweep_active, r_trig_overrun;
  logic [11:0] r_vid_out, r_range_idx;

  int checks = 0;
  int errors = 0;

  stc_prog #(.RETRIG(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_trig(trig),
    .i_sample_en(sample_en), .i_vid_in(vid_in),
    .i_bypass(bypass), .i_cfg_we(cfg_we),
    .i_cfg_addr(cfg_addr), .i_cfg_range(cfg_range),
    .i_cfg_gain(cfg_gain), .o_cfg_err(o_cfg_err),
    .o_vid_out(o_vid_out), .o_vid_valid(o_vid_valid),
    .o_sweep_active(o_sweep_active),
    .o_range_idx(o_range_idx),
    .o_trig_overrun(o_trig_overrun));

  stc_prog #(.RETRIG(1)) u_rt (
    .i_clk(clk), .i_rst(rst), .i_trig(trig),
    .i_sample_en(sample_en), .i_vid_in(vid_in),
    .i_bypass(bypass), .i_cfg_we(cfg_we),
    .i_cfg_addr(cfg_addr), .i_cfg_range(cfg_range),
    .i_cfg_gain(cfg_gain), .o_cfg_err(r_cfg_err),
    .o_vid_out(r_vid_out), .o_vid_valid(r_vid_valid),
    .o_sweep_active(r_sweep_active),
    .o_range_idx(r_range_idx),
    .o_trig_overrun(r_trig_overrun));

  always #5 clk = ~clk;

  // model state
  int m_k;
  bit m_tdp;
  int a_rng[SEGS], a_gain[SEGS];
  int s_rng[SEGS], s_gain[SEGS];
  bit m_v1, m_vv, m_err, m_ovr;
  int m_y1, m_vo;
  int lit_q[$];

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               n, a, e);
    end
  endtask

  // Entry used at range k: last entry of the
  // ascending prefix whose start range is <= k.
  function automatic int gain_at(int k);
    int i;
    i = 0;
    for (int j = 1; j < SEGS; j++) begin
      if (a_rng[j] <= a_rng[j-1]) break;
      if (k >= a_rng[j]) i = j;
    end
    return a_gain[i];
  endfunction

  task automatic step();
    int kk, g, y, e;
    bit edg, act, start;
    if (!rst) begin
      m_k = LIM; m_tdp = 0;
      m_v1 = 0; m_vv = 0; m_y1 = 0; m_vo = 0;
      m_err = 0; m_ovr = 0;
      for (int i = 0; i < SEGS; i++) begin
        a_rng[i] = 0; a_gain[i] = UNITY;
        s_rng[i] = 0; s_gain[i] = UNITY;
      end
      lit_q.delete();
    end else begin
      edg   = trig && !m_tdp;
      act   = m_k < LIM;
      start = edg && !act;
      m_err = cfg_we && (act || edg);
      m_ovr = edg && act;
      if (start)
        for (int i = 0; i < SEGS; i++) begin
          a_rng[i] = s_rng[i];
          a_gain[i] = s_gain[i];
        end
      if (cfg_we && !act && !edg) begin
        s_rng[cfg_addr]  = cfg_range;
        s_gain[cfg_addr] = cfg_gain;
      end
      kk = start ? 0 : (act ? m_k : LIM - 1);
      g  = bypass ? UNITY : gain_at(kk);
      y  = (int'(vid_in) * g) >> 11;
      if (y > 4095) y = 4095;
      if (m_v1) m_vo = m_y1;
      m_vv = m_v1;
      m_v1 = sample_en;
      m_y1 = y;
      if (start) m_k = sample_en ? 1 : 0;
      else if (act && sample_en) m_k++;
      m_tdp = trig;
    end
    @(posedge clk);
    #1;
    chk("range_idx", o_range_idx, m_k);
    chk("sweep_active", o_sweep_active, m_k < LIM);
    chk("vid_valid", o_vid_valid, m_vv);
    chk("vid_out", o_vid_out, m_vo);
    chk("cfg_err", o_cfg_err, m_err);
    chk("trig_overrun", o_trig_overrun, m_ovr);
    if (m_vv && lit_q.size() > 0) begin
      e = lit_q.pop_front();
      if (e >= 0) chk("vid_lit", o_vid_out, e);
    end
  endtask

  task automatic idle(int n);
    sample_en = 0;
    repeat (n) step();
  endtask

  task automatic samp(int v, int e);
    sample_en = 1;
    vid_in = 12'(v);
    lit_q.push_back(e);
    step();
    sample_en = 0;
  endtask

  task automatic wr(int a, int r, int g);
    cfg_we = 1;
    cfg_addr = 4'(a);
    cfg_range = 12'(r);
    cfg_gain = 12'(g);
    step();
    cfg_we = 0;
  endtask

  task automatic pulse_trig();
    trig = 1;
    step();
    trig = 0;
  endtask

  task automatic finish_sweep(int v, int e);
    for (int i = 0; i < 3000 && m_k < LIM; i++)
      samp(v, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    rst = 0;
    repeat (3) step();
    chk("rst_range", o_range_idx, 2626);
    chk("rst_active", o_sweep_active, 0);
    chk("rst_valid", o_vid_valid, 0);
    rst = 1;
    step();

    // unity gain after reset
    pulse_trig();
    chk("start_range", o_range_idx, 0);
    chk("start_active", o_sweep_active, 1);
    for (int i = 0; i < 10; i++) samp(1000, 1000);
    idle(3);
    finish_sweep(500, 500);
    chk("end_active", o_sweep_active, 0);
    idle(2);

    // three-segment table
    wr(0, 0, 12'h100);
    wr(1, 100, 12'h800);
    wr(2, 200, 12'hC00);
    samp(2048, 2048);
    pulse_trig();
    for (int i = 0; i < 3000 && m_k < LIM; i++)
      samp(2048, m_k < 100 ? 256 :
                 m_k < 200 ? 2048 : 3072);
    samp(2048, 3072);
    bypass = 1;
    samp(2048, 2048);
    bypass = 0;
    idle(3);

    // saturation and zero gain, overrun, cfg reject
    wr(0, 0, 12'hFFF);
    wr(1, 1, 12'h000);
    wr(2, 0, 12'h800);
    pulse_trig();
    samp(4095, 4095);
    samp(4095, 0);
    for (int i = 0; i < 600 && m_k < 500; i++)
      samp(100, 0);
    idle(2);
    wr(0, 0, 12'h400);
    chk("cfg_err_lit", o_cfg_err, 1);
    trig = 1;
    step();
    chk("ovr_lit", o_trig_overrun, 1);
    chk("ovr_range", o_range_idx, 500);
    chk("rt_range", r_range_idx, 0);
    chk("rt_ovr", r_trig_overrun, 1);
    trig = 0;
    idle(2);
    finish_sweep(100, 0);
    chk("lim_range", o_range_idx, 2626);
    chk("lim_active", o_sweep_active, 0);
    idle(2);

    // rejected write left table intact
    pulse_trig();
    samp(4095, 4095);
    finish_sweep(7, 0);
    idle(2);

    // same write while idle applies next sweep
    wr(0, 0, 12'h400);
    chk("cfg_ok_lit", o_cfg_err, 0);
    samp(4095, 0);
    pulse_trig();
    samp(2048, 1024);
    samp(2048, 0);
    for (int i = 0; i < 2000 && m_k < 1500; i++)
      samp(10, 0);

    // reset mid-sweep with samples in flight
    samp(2000, -1);
    rst = 0;
    sample_en = 1;
    vid_in = 12'd2048;
    step();
    sample_en = 0;
    chk("mrst_valid", o_vid_valid, 0);
    chk("mrst_range", o_range_idx, 2626);
    chk("mrst_active", o_sweep_active, 0);
    rst = 1;
    step();
    pulse_trig();
    samp(2048, 2048);
    samp(4095, 4095);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
